// File: rtl/prga_encrypt_if.sv
// Handshake and memory-port bundle for the ARC4 encrypt keystream engine.
// slave = engine side, master = memories/controller side.
interface prga_encrypt_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;

  modport slave (
    input  en, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  modport master (
    output en, s_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/prga_encrypt.sv
// ARC4 keystream engine: encrypts a length-prefixed PT buffer into CT using a
// pre-scheduled S-box, six cycles per byte over a single S port.
module prga_encrypt (
  input  logic            clk,
  input  logic            rst_n,
  prga_encrypt_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_REQ, LEN_WR, I_RD, J_RD, SWAP_I, SWAP_J, PAD_RD, XOR_WR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d, si_q, si_d, sj_q, sj_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    len_d   = len_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      IDLE: if (bus.en) begin
        i_d     = '0;
        j_d     = '0;
        k_d     = 8'd1;
        state_d = LEN_REQ;
      end
      LEN_REQ: state_d = LEN_WR;
      LEN_WR: begin
        len_d   = bus.pt_rddata;
        state_d = (bus.pt_rddata == 8'd0) ? IDLE : I_RD;
      end
      I_RD: begin
        i_d     = i_q + 8'd1;
        state_d = J_RD;
      end
      J_RD: begin
        si_d    = bus.s_rddata;
        j_d     = j_q + bus.s_rddata;
        state_d = SWAP_I;
      end
      SWAP_I: begin
        sj_d    = bus.s_rddata;
        state_d = SWAP_J;
      end
      SWAP_J: state_d = PAD_RD;
      PAD_RD: state_d = XOR_WR;
      // Compare before increment so L=255 finishes without k wrapping.
      XOR_WR: if (k_q == len_q) begin
        state_d = IDLE;
      end else begin
        k_d     = k_q + 8'd1;
        state_d = I_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rdy       = 1'b0;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.s_wren    = 1'b0;
    bus.pt_addr   = '0;
    bus.ct_addr   = '0;
    bus.ct_wrdata = '0;
    bus.ct_wren   = 1'b0;
    case (state_q)
      IDLE:    bus.rdy = 1'b1;
      LEN_REQ: bus.pt_addr = 8'd0;
      LEN_WR: begin
        bus.ct_addr   = 8'd0;
        bus.ct_wrdata = bus.pt_rddata;
        bus.ct_wren   = 1'b1;
      end
      I_RD:    bus.s_addr = i_q + 8'd1;
      J_RD:    bus.s_addr = j_q + bus.s_rddata;
      // i==j needs no special case: both writes store the same byte.
      SWAP_I: begin
        bus.s_addr   = i_q;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
      end
      SWAP_J: begin
        bus.s_addr   = j_q;
        bus.s_wrdata = si_q;
        bus.s_wren   = 1'b1;
      end
      PAD_RD: begin
        bus.s_addr  = si_q + sj_q;
        bus.pt_addr = k_q;
      end
      XOR_WR: begin
        bus.ct_addr   = k_q;
        bus.ct_wrdata = bus.s_rddata ^ bus.pt_rddata;
        bus.ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_encrypt.sv
// Bench for prga_encrypt: memory models, an ARC4 reference model feeding a CT
// write scoreboard, and directed scenarios for vectors, wrap, handshake, reset.
module tb_prga_encrypt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prga_encrypt_if bus();

  prga_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } ctw_t;

  logic [7:0] smem  [256];
  logic [7:0] ptmem [256];
  logic [7:0] ctmem [256];
  logic [7:0] s_src [256];
  logic [7:0] ms    [256];
  logic       load_s = 1'b0;
  ctw_t       sbq [$];
  int         checks = 0;
  int         errors = 0;
  int         s_wr_cnt = 0;
  int         ct_wr_cnt = 0;

  always @(posedge clk) begin
    if (load_s) begin
      for (int a = 0; a < 256; a++) smem[a] <= s_src[a];
    end else if (bus.s_wren) begin
      smem[bus.s_addr] <= bus.s_wrdata;
    end
    bus.s_rddata  <= smem[bus.s_addr];
    bus.pt_rddata <= ptmem[bus.pt_addr];
    if (bus.ct_wren) ctmem[bus.ct_addr] <= bus.ct_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every CT write must match the next expected (addr,data).
  always @(negedge clk) begin
    ctw_t e;
    if (bus.s_wren === 1'b1) s_wr_cnt++;
    if (bus.ct_wren === 1'b1) begin
      ct_wr_cnt++;
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL ct_extra_write observed addr=%0h expected no write", bus.ct_addr);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ct_addr", {24'd0, bus.ct_addr}, {24'd0, e.addr});
        chk("ct_data", {24'd0, bus.ct_wrdata}, {24'd0, e.data});
      end
    end
  end

  function automatic logic [7:0] kbyte(input logic [63:0] key, input int klen, input int n);
    return key[8*(klen-1-n) +: 8];
  endfunction

  task automatic ksa(input logic [63:0] key, input int klen);
    logic [7:0] j, t;
    j = 8'd0;
    for (int a = 0; a < 256; a++) ms[a] = a[7:0];
    for (int a = 0; a < 256; a++) begin
      j = j + ms[a] + kbyte(key, klen, a % klen);
      t = ms[a]; ms[a] = ms[j]; ms[j] = t;
    end
  endtask

  task automatic load_smem();
    for (int a = 0; a < 256; a++) s_src[a] = ms[a];
    load_s = 1'b1;
    @(posedge clk); #1 load_s = 1'b0;
  endtask

  // Advances the model S-box through one message and queues its CT writes.
  task automatic push_expected();
    logic [7:0] i, j, t, ks;
    int L;
    L = ptmem[0];
    i = 8'd0; j = 8'd0;
    sbq.push_back('{addr: 8'd0, data: ptmem[0]});
    for (int k = 1; k <= L; k++) begin
      i = i + 8'd1;
      j = j + ms[i];
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      ks = ms[ms[i] + ms[j]];
      sbq.push_back('{addr: k[7:0], data: ptmem[k] ^ ks});
    end
  endtask

  task automatic fill_pt(input int L);
    ptmem[0] = L[7:0];
    for (int k = 1; k < 256; k++) ptmem[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_msg(input string tag, input int exp_busy);
    int busy;
    bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    busy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      busy++;
    end
    chk(tag, busy, exp_busy);
  endtask

  task automatic cmp_sbox(input string tag);
    int mism;
    mism = 0;
    for (int a = 0; a < 256; a++) if (smem[a] !== ms[a]) mism++;
    chk(tag, mism, 0);
  endtask

  logic [7:0] kv [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt_kv [10] = '{8'd9, "P", "l", "a", "i", "n", "t", "e", "x", "t"};

  initial begin
    int busy1, busy2, mism;
    logic [7:0] i, j, t, ks;

    rst_n  = 1'b0;
    bus.en = 1'b0;
    for (int a = 0; a < 256; a++) begin ptmem[a] = 8'd0; ms[a] = a[7:0]; end
    load_smem();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wrdata", bus.s_wrdata, 0);
    chk("rst_s_wren", bus.s_wren, 0);
    chk("rst_pt_addr", bus.pt_addr, 0);
    chk("rst_ct_addr", bus.ct_addr, 0);
    chk("rst_ct_wrdata", bus.ct_wrdata, 0);
    chk("rst_ct_wren", bus.ct_wren, 0);

    // Known vector: key "Key", plaintext "Plaintext".
    ksa(64'h4B6579, 3);
    load_smem();
    for (int n = 0; n < 10; n++) ptmem[n] = pt_kv[n];
    push_expected();
    run_msg("kv_busy", 56);
    for (int n = 0; n < 10; n++) chk("kv_ct", ctmem[n], kv[n]);
    cmp_sbox("kv_sbox");

    // Zero length: one CT write, S untouched.
    ptmem[0] = 8'd0;
    s_wr_cnt = 0; ct_wr_cnt = 0;
    push_expected();
    run_msg("zero_busy", 2);
    chk("zero_ct_writes", ct_wr_cnt, 1);
    chk("zero_s_writes", s_wr_cnt, 0);
    cmp_sbox("zero_sbox");

    // Identity S makes the first step hit i==j.
    for (int a = 0; a < 256; a++) ms[a] = a[7:0];
    load_smem();
    fill_pt(20);
    push_expected();
    run_msg("ieqj_busy", 122);
    cmp_sbox("ieqj_sbox");

    // 255-byte round trip through the decrypt direction of the model.
    ksa(64'h536563726574, 6);
    load_smem();
    fill_pt(255);
    ct_wr_cnt = 0;
    push_expected();
    run_msg("rt_busy", 2 + 6*255);
    chk("rt_ct_writes", ct_wr_cnt, 256);
    chk("rt_ct_len", ctmem[0], 255);
    ksa(64'h536563726574, 6);
    i = 8'd0; j = 8'd0; mism = 0;
    for (int k = 1; k <= 255; k++) begin
      i = i + 8'd1; j = j + ms[i];
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      ks = ms[ms[i] + ms[j]];
      if ((ctmem[k] ^ ks) !== ptmem[k]) mism++;
    end
    chk("rt_decrypt_mism", mism, 0);
    cmp_sbox("rt_sbox");

    // en pulsed mid-message is ignored.
    ksa(64'h0102030405, 5);
    load_smem();
    fill_pt(4);
    push_expected();
    bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    busy1 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      busy1++;
      if (c == 5) begin bus.en = 1'b1; @(posedge clk); #1 bus.en = 1'b0; end
    end
    chk("hs_pulse_busy", busy1, 26);
    repeat (3) begin @(negedge clk); chk("hs_pulse_idle", bus.rdy, 1); end

    // en held across completion restarts the cycle rdy is seen high.
    push_expected();
    push_expected();
    bus.en = 1'b1;
    @(posedge clk); #1;
    busy1 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.rdy) break;
      busy1++;
    end
    @(posedge clk); #1 bus.en = 1'b0;
    busy2 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) chk("hs_restart_rdy", bus.rdy, 0);
      if (bus.rdy) break;
      busy2++;
    end
    chk("hs_busy1", busy1, 26);
    chk("hs_busy2", busy2, 26);
    cmp_sbox("hs_sbox");

    // Reset during SWAP_I of byte 3 (cycle 17 after the start edge).
    ksa(64'hA5C3, 2);
    load_smem();
    fill_pt(6);
    push_expected();
    ct_wr_cnt = 0;
    bus.en = 1'b1;
    @(posedge clk); #1 bus.en = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_swap_i_wren", bus.s_wren, 1);
    chk("mid_ct_writes", ct_wr_cnt, 3);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", bus.rdy, 1);
    chk("mid_rst_s_wren", bus.s_wren, 0);
    chk("mid_rst_ct_wren", bus.ct_wren, 0);
    sbq.delete();
    ksa(64'hA5C3, 2);
    load_smem();
    push_expected();
    run_msg("mid_rerun_busy", 38);

    chk("sbq_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
